// File: rtl/spi_pkg.sv
// spi_pkg: encodings shared by the SPI master and the SPI-slave/RAM block so
// both ends agree on opcodes, frame geometry and the master state encoding.
package spi_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    M_IDLE      = 3'd0,
    M_START     = 3'd1,
    M_SHIFT_OUT = 3'd2,
    M_TURN      = 3'd3,
    M_SHIFT_IN  = 3'd4,
    M_GAP       = 3'd5
  } master_state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: 10-bit parallel-in/serial-out for MOSI and a serial-in
// collector for MISO.
//  clk, rst   : clock, synchronous active-high reset
//  load       : capture frame_in into the PISO, clear the MISO collector
//  frame_in   : {opcode, payload} frame, MSB sent first
//  shift      : drive the next PISO bit onto mosi at this edge (else mosi=0)
//  sample     : shift miso into the collector at this edge
//  miso       : serial data from the slave
//  mosi       : registered serial data to the slave
//  rx_byte    : collected bits plus the live miso bit, i.e. the byte that
//               results if this edge is the last sample edge
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               shift,
  input  logic               sample,
  input  logic               miso,
  output logic               mosi,
  output logic [DATA_W-1:0]  rx_byte
);

  logic [FRAME_W-1:0] piso;
  // Only DATA_W-1 bits need storing; the final bit is taken live from miso.
  logic [DATA_W-2:0]  sipo;

  assign rx_byte = {sipo, miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      piso <= '0;
      sipo <= '0;
      mosi <= 1'b0;
    end else begin
      if (load) begin
        piso <= frame_in;
      end else if (shift) begin
        piso <= {piso[FRAME_W-2:0], 1'b0};
      end

      mosi <= shift ? piso[FRAME_W-1] : 1'b0;

      if (load) begin
        sipo <= '0;
      end else if (sample) begin
        sipo <= rx_byte[DATA_W-2:0];
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: single-clock SPI master. Turns host commands into 10-bit
// MSB-first frames on MOSI/SS_n and, for read-data frames, collects the byte
// the slave returns on MISO.
//  clk, rst             : clock, synchronous active-high reset
//  cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//  cmd_op, cmd_data     : opcode and payload (payload sent as 0 for op 11)
//  rd_data, rd_valid    : returned byte and its one-cycle strobe
//  busy                 : high from acceptance until back in IDLE
//  MOSI, MISO, SS_n     : serial link to the slave
//  frame_cnt            : completed-frame counter, only present when
//                         SPI_MASTER_FRAME_CNT_EN is defined
// Parameters: RD_WAIT turnaround cycles before MISO sampling, GAP_CYC SS_n-high
// cycles after each frame (at least 1).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS_n
`ifdef SPI_MASTER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [3:0] OUT_LOAD  = 4'(FRAME_W - 1);
  localparam logic [3:0] IN_LOAD   = 4'(DATA_W - 1);
  localparam logic [3:0] TURN_LOAD = 4'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
  localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  master_state_t      state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic               is_rd;
  logic               load, shift, sample, rd_done;
  logic [DATA_W-1:0]  payload;
  logic [DATA_W-1:0]  rx_byte;
  logic               in_frame;

  always_comb begin
    payload = (cmd_op == CMD_RD_DATA) ? '0 : cmd_data;
  end

  assign in_frame = (state != M_IDLE);

  spi_master_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .frame_in ({cmd_op, payload}),
    .shift    (shift),
    .sample   (sample),
    .miso     (MISO),
    .mosi     (MOSI),
    .rx_byte  (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= M_IDLE;
      cnt   <= '0;
      is_rd <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        is_rd <= (cmd_op == CMD_RD_DATA);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt - 4'd1;
    load    = 1'b0;
    sample  = 1'b0;
    rd_done = 1'b0;
    case (state)
      M_IDLE: begin
        cnt_n = cnt;
        if (cmd_valid) begin
          state_n = M_START;
          load    = 1'b1;
        end
      end
      M_START: begin
        state_n = M_SHIFT_OUT;
        cnt_n   = OUT_LOAD;
      end
      M_SHIFT_OUT: begin
        if (cnt == '0) begin
          if (!is_rd) begin
            state_n = M_GAP;
            cnt_n   = GAP_LOAD;
          end else if (RD_WAIT == 0) begin
            state_n = M_SHIFT_IN;
            cnt_n   = IN_LOAD;
          end else begin
            state_n = M_TURN;
            cnt_n   = TURN_LOAD;
          end
        end
      end
      M_TURN: begin
        if (cnt == '0) begin
          state_n = M_SHIFT_IN;
          cnt_n   = IN_LOAD;
        end
      end
      M_SHIFT_IN: begin
        sample = 1'b1;
        if (cnt == '0) begin
          state_n = M_GAP;
          cnt_n   = GAP_LOAD;
          rd_done = 1'b1;
        end
      end
      M_GAP: begin
        if (cnt == '0) begin
          state_n = M_IDLE;
        end
      end
      default: begin
        state_n = M_IDLE;
        cnt_n   = '0;
      end
    endcase
    // Outputs are registered from the next state, so MOSI carries bit N
    // in the cycle the FSM spends on bit N.
    shift = (state_n == M_SHIFT_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SS_n      <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      SS_n      <= (state_n == M_IDLE) || (state_n == M_GAP);
      cmd_ready <= (state_n == M_IDLE);
      busy      <= (state_n != M_IDLE);
      rd_valid  <= rd_done;
    end
  end

  // A reset that lands in the middle of a frame only aborts the frame; the
  // last completed read byte (and frame count) survive it. A reset seen
  // while idle returns them to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!in_frame) begin
        rd_data <= '0;
      end
    end else if (rd_done) begin
      rd_data <= rx_byte;
    end
  end

`ifdef SPI_MASTER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!in_frame) begin
        frame_cnt <= '0;
      end
    end else if (state_n == M_GAP && state != M_GAP) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int unsigned RD_WAIT = 1;
  localparam int unsigned GAP_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       MOSI;
  logic       MISO;
  logic       SS_n;
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .SS_n      (SS_n)
`ifdef SPI_MASTER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] frame_q [$];
  logic [7:0] rd_q    [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_fc(input string name, input logic [15:0] exp);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check(name, frame_cnt, exp);
`else
    if (exp == 16'hFFFF) $display("note: %s", name);
`endif
  endtask

  // Slave/RAM model: decodes frames seen on MOSI, checks them against the
  // frame scoreboard and answers read-data frames on MISO.
  logic [7:0] ram [256];
  logic [7:0] s_addr, s_rptr, s_rbyte;
  logic [9:0] s_sr;
  logic       s_rd;
  int         s_cyc;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    MISO = 1'b0; s_cyc = 0; s_rd = 1'b0; s_addr = '0; s_rptr = '0; s_sr = '0; s_rbyte = '0;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        s_cyc = 0; s_rd = 1'b0; MISO = 1'b0;
      end else begin
        s_cyc++;
        if (s_cyc >= 2 && s_cyc <= 11) s_sr = {s_sr[8:0], MOSI};
        if (s_cyc == 11) begin
          if (frame_q.size() == 0) check("frame_unexpected", 1, 0);
          else check("frame", {22'd0, s_sr}, {22'd0, frame_q.pop_front()});
          case (s_sr[9:8])
            2'b00:   s_addr = s_sr[7:0];
            2'b01:   ram[s_addr] = s_sr[7:0];
            2'b10:   s_rptr = s_sr[7:0];
            default: begin s_rd = 1'b1; s_rbyte = ram[s_rptr]; end
          endcase
        end
        if (s_rd && s_cyc >= 12 + RD_WAIT && s_cyc <= 19 + RD_WAIT)
          MISO = s_rbyte[19 + RD_WAIT - s_cyc];
        else
          MISO = 1'b0;
      end
    end
  end

  // Read-data monitor: every rd_valid strobe must match a queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (rd_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
  endtask

  // Cycle-by-cycle check of one frame; cycle k is sampled at the k-th
  // negedge after the accept edge.
  task automatic frame_cycles(input logic rd, input logic [9:0] f, input int n, input string tag);
    int last;
    last = rd ? 20 : 11;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check($sformatf("%s SS_n c%0d", tag, k), SS_n, (k > last));
      check($sformatf("%s cmd_ready c%0d", tag, k), cmd_ready, (k >= last + 3));
      check($sformatf("%s busy c%0d", tag, k), busy, (k < last + 3));
      check($sformatf("%s MOSI c%0d", tag, k), MOSI, (k >= 2 && k <= 11) ? f[11 - k] : 1'b0);
      check($sformatf("%s rd_valid c%0d", tag, k), rd_valid, (rd && k == 21));
    end
  endtask

  task automatic run_frame(input logic [1:0] op, input logic [7:0] d, input logic [9:0] f,
                           input logic rd, input logic [7:0] exp_rd, input string tag);
    frame_q.push_back(f);
    if (rd) rd_q.push_back(exp_rd);
    send(op, d);
    frame_cycles(rd, f, rd ? 23 : 14, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int n_acc, acc_a, acc_b;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst SS_n", SS_n, 1);
    check("rst MOSI", MOSI, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst busy", busy, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 8'h00);
    check_fc("rst frame_cnt", 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_frame(2'b00, 8'h35, 10'h035, 1'b0, 8'h00, "wr_addr");
    run_frame(2'b01, 8'h95, 10'h195, 1'b0, 8'h00, "wr_data");
    run_frame(2'b10, 8'h35, 10'h235, 1'b0, 8'h00, "rd_addr");
    run_frame(2'b11, 8'hA7, 10'h300, 1'b1, 8'h95, "rd_data");
    repeat (3) @(negedge clk);
    check("rd_data hold", rd_data, 8'h95);

    run_frame(2'b10, 8'h00, 10'h200, 1'b0, 8'h00, "rd_addr0");
    run_frame(2'b11, 8'hFF, 10'h300, 1'b1, 8'h00, "rd_zero");
    run_frame(2'b10, 8'h35, 10'h235, 1'b0, 8'h00, "rd_addr35");
    run_frame(2'b11, 8'h00, 10'h300, 1'b1, 8'h95, "rd_again");
    check_fc("frame_cnt after 8", 16'd8);

    // Reset during cycle 6 of a read-data frame.
    send(2'b11, 8'h12);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst SS_n", SS_n, 1);
    check("midrst MOSI", MOSI, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst rd_valid", rd_valid, 0);
    check("midrst rd_data", rd_data, 8'h95);
    check_fc("midrst frame_cnt", 16'd8);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst rd_data later", rd_data, 8'h95);

    // cmd_valid held for 40 cycles; command changes right after acceptance.
    frame_q.push_back(10'h040);
    frame_q.push_back(10'h15A);
    frame_q.push_back(10'h15A);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h40;
    @(posedge clk);
    #1;
    cmd_op = 2'b01; cmd_data = 8'h5A;
    frame_cycles(1'b0, 10'h040, 14, "busy");
    n_acc = 0; acc_a = 0; acc_b = 0;
    for (int k = 14; k <= 39; k++) begin
      if (k > 14) @(negedge clk);
      if (cmd_ready === 1'b1 && cmd_valid === 1'b1) begin
        n_acc++;
        if (n_acc == 1) acc_a = k;
        else acc_b = k;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy accepts", n_acc, 2);
    check("busy accept1 cycle", acc_a, 14);
    check("busy accept2 cycle", acc_b, 28);
    repeat (5) @(negedge clk);
    check_fc("frame_cnt after busy", 16'd11);

    run_frame(2'b10, 8'h40, 10'h240, 1'b0, 8'h00, "rd_addr40");
    run_frame(2'b11, 8'h00, 10'h300, 1'b1, 8'h5A, "rd_busy");
    check_fc("frame_cnt after 13", 16'd13);

    // rst and cmd_valid together: reset wins.
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h11;
    @(negedge clk);
    check("rstcmd cmd_ready", cmd_ready, 1);
    check("rstcmd busy", busy, 0);
    check("rstcmd SS_n", SS_n, 1);
    check("rstcmd rd_data", rd_data, 8'h00);
    check_fc("rstcmd frame_cnt", 16'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("rstcmd idle SS_n", SS_n, 1);
    check("rstcmd idle busy", busy, 0);

    repeat (5) @(negedge clk);
    check("frame_q empty", frame_q.size(), 0);
    check("rd_q empty", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
